uart_cmd_rx: RTL and testbench



---
 rtl/uart_cmd_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: oversampling 8N1 UART receiver that pairs bytes into 16-bit commands on a ready/clear handshake.
// Define UART_FRM_CHK_EN to drop bytes with a bad stop bit, pulse frm_err, and wait one idle bit before re-arming.
module uart_cmd_rx #(
  parameter int unsigned BAUD_DIV     = 2604,
  parameter int unsigned INTERBYTE_TO = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned TO_W  = $clog2(INTERBYTE_TO + 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(INTERBYTE_TO);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       sr;
  logic             rx_m, rx_s, rx_p;
  logic [1:0]       sync_fill;
  logic             armed;
  logic             idx;
  logic [7:0]       hold;
  logic [TO_W-1:0]  to_cnt;

  logic fall_c, byte_done_c, accept_c, timeout_c;

  // armed only after a real (post-synchroniser) high sample, so reset values never fake an edge
  assign fall_c      = armed && rx_p && !rx_s;
  assign byte_done_c = (state == STOP) && (cnt == '0);
  assign timeout_c   = idx && (state == IDLE) && (to_cnt == TO_LIMIT);
`ifdef UART_FRM_CHK_EN
  assign accept_c    = byte_done_c && rx_s;
  logic rearm;
`else
  assign accept_c    = byte_done_c;
  assign frm_err     = 1'b0;
`endif

  // RX synchroniser and previous-sample register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_p      <= 1'b1;
      sync_fill <= '0;
    end else begin
      rx_m      <= RX;
      rx_s      <= rx_m;
      rx_p      <= rx_s;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Bit-level receiver
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      armed   <= 1'b0;
`ifdef UART_FRM_CHK_EN
      rearm   <= 1'b0;
      frm_err <= 1'b0;
`endif
    end else begin
`ifdef UART_FRM_CHK_EN
      frm_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (fall_c) begin
            cnt   <= HALF_BIT;
            state <= START;
          end
`ifdef UART_FRM_CHK_EN
          else if (rearm) begin
            // line must stay high a full bit time before edges count again
            if (!rx_s) cnt <= FULL_BIT;
            else if (cnt == '0) begin
              rearm <= 1'b0;
              armed <= 1'b1;
            end else cnt <= cnt - 1'b1;
          end
`endif
          else if (sync_fill[1] && rx_s) armed <= 1'b1;
        end
        START: begin
          if (cnt == '0) begin
            if (rx_s) state <= IDLE;
            else begin
              cnt     <= FULL_BIT;
              bit_cnt <= '0;
              state   <= DATA;
            end
          end else cnt <= cnt - 1'b1;
        end
        DATA: begin
          if (cnt == '0) begin
            sr      <= {rx_s, sr[7:1]};
            cnt     <= FULL_BIT;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else cnt <= cnt - 1'b1;
        end
        STOP: begin
          if (cnt == '0) begin
            state <= IDLE;
`ifdef UART_FRM_CHK_EN
            if (!rx_s) begin
              frm_err <= 1'b1;
              armed   <= 1'b0;
              rearm   <= 1'b1;
              cnt     <= FULL_BIT;
            end
`endif
          end else cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte pairing, inter-byte timeout and cmd_rdy handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 1'b0;
      hold    <= '0;
      to_cnt  <= '0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      if (accept_c) begin
        if (idx) begin
          cmd     <= {hold, sr};
          cmd_rdy <= 1'b1;
          idx     <= 1'b0;
        end else begin
          hold    <= sr;
          idx     <= 1'b1;
          to_cnt  <= '0;
          cmd_rdy <= 1'b0;
        end
      end
`ifdef UART_FRM_CHK_EN
      else if (byte_done_c) begin
        idx  <= 1'b0;
        hold <= '0;
      end
`endif
      else if (timeout_c) begin
        idx    <= 1'b0;
        hold   <= '0;
        to_cnt <= '0;
      end else if (fall_c && (state == IDLE)) begin
        to_cnt <= '0;
      end else if (idx && (state == IDLE)) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed and randomized byte traffic for uart_cmd_rx, checked every cycle against a frame-level model.
// Build with UART_FRM_CHK_EN defined to exercise the stop-bit check variant.
module tb_uart_cmd_rx;

  localparam int B      = 16;
  localparam int H      = B / 2;
  localparam int TO_CYC = 500;
  // edge of the stop-bit sample, relative to the edge after which the start bit is driven
  localparam int STOP_OFS   = 4 + H + 9 * B;
  localparam int DETECT_OFS = 3;
`ifdef UART_FRM_CHK_EN
  localparam bit FRM = 1'b1;
`else
  localparam bit FRM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  uart_cmd_rx #(.BAUD_DIV(B), .INTERBYTE_TO(TO_CYC)) dut (
    .clk(clk), .rst(rst), .RX(RX), .clr_cmd_rdy(clr_cmd_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         detect;
    int         done;
    logic [7:0] data;
    bit         stop_ok;
  } byte_ev_t;

  byte_ev_t pend[$];
  int       pend_rd = 0;
  byte_ev_t ev;

  string       lit_name[$];
  int          lit_sel[$];
  logic [31:0] lit_exp[$];
  int          lit_rd = 0;

  int   checks = 0, failures = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  bit   rand_clr = 1'b0;
  int   clr_at = -10;
  int   ref_k = 0;
  int   rise_cyc = -1;
  int   err_cnt = 0;
  bit   prev_rdy = 1'b0;

  logic [15:0] m_cmd = '0;
  bit          m_rdy = 1'b0, m_err = 1'b0, m_idx = 1'b0;
  logic [7:0]  m_hold = '0;
  int          m_t1 = 0;

  // Frame-level model: decoded bytes arrive at their stop-sample edge and are paired by rule
  always @(posedge clk) begin
    cyc = cyc + 1;
    m_err = 1'b0;
    if (rst) begin
      m_cmd = '0; m_rdy = 1'b0; m_idx = 1'b0; m_hold = '0;
      pend_rd = pend.size();
    end else begin
      if (clr_cmd_rdy) m_rdy = 1'b0;
      if (pend_rd < pend.size() && pend[pend_rd].done == cyc) begin
        ev = pend[pend_rd];
        pend_rd++;
        if (!ev.stop_ok && FRM) begin
          m_err = 1'b1; m_idx = 1'b0;
        end else if (m_idx && (ev.detect - m_t1) < TO_CYC) begin
          m_cmd = {m_hold, ev.data}; m_rdy = 1'b1; m_idx = 1'b0;
        end else begin
          m_hold = ev.data; m_idx = 1'b1; m_t1 = cyc; m_rdy = 1'b0;
        end
      end
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Compare process: model every cycle, plus queued literal expectations
  always @(negedge clk) begin
    logic [31:0] act;
    if (chk_en) begin
      if (cmd_rdy === 1'b1 && !prev_rdy) rise_cyc = cyc;
      prev_rdy = (cmd_rdy === 1'b1);
      if (frm_err === 1'b1) err_cnt++;
      check("cmd", 32'(cmd), 32'(m_cmd));
      check("cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
      check("frm_err", 32'(frm_err), 32'(m_err));
      while (lit_rd < lit_name.size()) begin
        case (lit_sel[lit_rd])
          0: act = 32'(cmd);
          1: act = 32'(cmd_rdy);
          2: act = 32'(frm_err);
          3: act = 32'(rise_cyc - ref_k);
          default: act = 32'(err_cnt);
        endcase
        check(lit_name[lit_rd], act, lit_exp[lit_rd]);
        lit_rd++;
      end
    end
  end

  task automatic expect_lit(input string name, input int sel, input logic [31:0] exp);
    lit_name.push_back(name);
    lit_sel.push_back(sel);
    lit_exp.push_back(exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr_cmd_rdy = rand_clr ? ($urandom_range(0, 7) == 0) : (clr_at == cyc + 1);
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    byte_ev_t e;
    e.detect  = cyc + DETECT_OFS;
    e.done    = cyc + STOP_OFS;
    e.data    = b;
    e.stop_ok = stop_ok;
    pend.push_back(e);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) RX = 1'b0;
      else if (i == 9) RX = stop_ok;
      else RX = b[i-1];
      repeat (B) tick();
    end
    RX = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    tick();
  endtask

  logic [7:0] r_b;
  bit         r_ok;
  int         r_sel;

  initial begin
    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0;
    tick();
    chk_en = 1'b1;
    expect_lit("reset_cmd", 0, 32'h0);
    expect_lit("reset_rdy", 1, 32'h0);
    expect_lit("reset_err", 2, 32'h0);
    tick(); tick();
    rst = 1'b0;
    idle(20);

    // back-to-back frame, rdy timing and hold
    send_byte(8'hA5, 1'b1);
    ref_k = cyc;
    send_byte(8'h3C, 1'b1);
    expect_lit("t1_rise_delay", 3, 32'd156);
    idle(10);
    expect_lit("t1_cmd", 0, 32'hA53C);
    expect_lit("t1_rdy_held", 1, 32'h1);

    // lone first byte clears rdy, keeps cmd
    send_byte(8'h12, 1'b1);
    expect_lit("t2_rdy_clr", 1, 32'h0);
    expect_lit("t2_cmd_kept", 0, 32'hA53C);
    send_byte(8'h34, 1'b1);
    expect_lit("t2_cmd", 0, 32'h1234);
    expect_lit("t2_rdy", 1, 32'h1);
    idle(5);
    pulse_clr();
    expect_lit("t1_rdy_after_clr", 1, 32'h0);
    idle(10);

    // false start, then a frame whose completion collides with clr
    RX = 1'b0;
    repeat (4) tick();
    idle(30);
    send_byte(8'h55, 1'b1);
    clr_at = cyc + STOP_OFS;
    send_byte(8'hAA, 1'b1);
    clr_at = -10;
    expect_lit("t3_cmd", 0, 32'h55AA);
    expect_lit("t3_set_wins", 1, 32'h1);
    idle(10);

    // inter-byte timeout drops the first byte
    send_byte(8'h77, 1'b1);
    idle(600);
    send_byte(8'h11, 1'b1);
    idle(20);
    send_byte(8'h22, 1'b1);
    expect_lit("t4_cmd", 0, 32'h1122);
    idle(10);

    // reset in the middle of the second byte
    send_byte(8'h5A, 1'b1);
    RX = 1'b0;
    repeat (B) tick();
    for (int i = 0; i < 4; i++) begin
      RX = i[0];
      repeat (B) tick();
    end
    RX = 1'b0;
    repeat (H) tick();
    rst = 1'b1; RX = 1'b1;
    tick();
    rst = 1'b0;
    expect_lit("t5_rst_cmd", 0, 32'h0);
    expect_lit("t5_rst_rdy", 1, 32'h0);
    idle(40);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    expect_lit("t5_cmd", 0, 32'hBEEF);
    idle(10);

    // bad stop bit
    send_byte(8'hC3, 1'b0);
    idle(40);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(2);
`ifdef UART_FRM_CHK_EN
    expect_lit("t6_cmd", 0, 32'h0102);
    expect_lit("t6_rdy", 1, 32'h1);
    expect_lit("t6_err_pulses", 4, 32'd1);
`else
    expect_lit("t6_cmd", 0, 32'hC301);
    expect_lit("t6_rdy", 1, 32'h0);
    expect_lit("t6_err_pulses", 4, 32'd0);
`endif
    idle(40);

    // randomized traffic with random clears, timeouts, false starts and bad stops
    rand_clr = 1'b1;
    for (int n = 0; n < 120; n++) begin
      r_b   = 8'($urandom);
      r_ok  = ($urandom_range(0, 9) != 0);
      send_byte(r_b, r_ok);
      r_sel = $urandom_range(0, 9);
      if (!r_ok) idle(40 + r_sel);
      else if (r_sel == 0) idle(700);
      else if (r_sel == 1) begin
        RX = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        idle(16 + $urandom_range(0, 10));
      end else idle($urandom_range(0, 30));
    end
    rand_clr = 1'b0;
    idle(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
